// File: rtl/xillybus_frame_sched.sv
// rtl/xillybus_frame_sched.sv - frame scheduler between Xillybus 32-bit FIFOs and a block core
module xillybus_frame_sched #(
    parameter int FRAME_WORDS  = 1024,
    parameter int RESULT_WORDS = 1024,
    parameter int TIMEOUT      = 65535
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        user_w_write_32_open,
    input  logic        user_r_read_32_open,
    input  logic        in_fifo_empty,
    input  logic [31:0] in_fifo_data,
    output logic        in_fifo_rd_en,
    output logic        core_in_valid,
    input  logic        core_in_ready,
    output logic [31:0] core_in_data,
    output logic        core_start,
    input  logic        core_done,
    output logic        core_abort,
    input  logic        core_out_valid,
    output logic        core_out_ready,
    input  logic [31:0] core_out_data,
    input  logic        out_fifo_full,
    output logic        out_fifo_wr_en,
    output logic [31:0] out_fifo_data,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        err_timeout,
    output logic        err_dropped
);
    localparam int LW = $clog2(FRAME_WORDS);
    localparam int DW = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] LD_LAST  = LW'(FRAME_WORDS - 1);
    localparam logic [DW-1:0] DR_LAST  = DW'(RESULT_WORDS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [LW-1:0] ld_cnt_q, ld_cnt_d;
    logic [DW-1:0] dr_cnt_q, dr_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          start_q, start_d;
    logic          abort_q, abort_d;
    logic          err_tmo_q, err_tmo_d;
    logic          err_drop_q, err_drop_d;
    logic          ld_fire, dr_fire;

    // Handshakes are combinational so a word can move every cycle.
    always_comb begin
        in_fifo_rd_en  = 1'b0;
        core_in_valid  = 1'b0;
        core_out_ready = 1'b0;
        out_fifo_wr_en = 1'b0;
        case (state_q)
            S_IDLE: in_fifo_rd_en = !user_w_write_32_open && !in_fifo_empty;
            S_LOAD: begin
                core_in_valid = user_w_write_32_open && !in_fifo_empty;
                in_fifo_rd_en = core_in_valid && core_in_ready;
            end
            S_DRAIN: begin
                core_out_ready = user_r_read_32_open ? !out_fifo_full : 1'b1;
                out_fifo_wr_en = user_r_read_32_open && core_out_valid && !out_fifo_full;
            end
            default: ;
        endcase
    end

    assign ld_fire = core_in_valid && core_in_ready;
    assign dr_fire = core_out_valid && core_out_ready;

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        dr_cnt_d    = dr_cnt_q;
        timer_d     = timer_q;
        frame_cnt_d = frame_cnt_q;
        start_d     = 1'b0;
        abort_d     = 1'b0;
        err_tmo_d   = err_tmo_q;
        err_drop_d  = err_drop_q;
        case (state_q)
            S_IDLE: begin
                if (user_w_write_32_open && user_r_read_32_open && !in_fifo_empty)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                if (!user_w_write_32_open) begin
                    ld_cnt_d = '0;
                    abort_d  = 1'b1;
                    state_d  = S_IDLE;
                end else if (ld_fire) begin
                    if (ld_cnt_q == LD_LAST) begin
                        ld_cnt_d = '0;
                        start_d  = 1'b1;
                        state_d  = S_START;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // done on the timeout cycle still lets the frame complete
                if (core_done) begin
                    dr_cnt_d = '0;
                    state_d  = S_DRAIN;
                end else if (timer_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    abort_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (dr_fire) begin
                    if (!user_r_read_32_open)
                        err_drop_d = 1'b1;
                    if (dr_cnt_q == DR_LAST) begin
                        dr_cnt_d    = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_IDLE;
                    end else begin
                        dr_cnt_d = dr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            state_q     <= S_IDLE;
            ld_cnt_q    <= '0;
            dr_cnt_q    <= '0;
            timer_q     <= '0;
            frame_cnt_q <= '0;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            dr_cnt_q    <= dr_cnt_d;
            timer_q     <= timer_d;
            frame_cnt_q <= frame_cnt_d;
            start_q     <= start_d;
            abort_q     <= abort_d;
            err_tmo_q   <= err_tmo_d;
            err_drop_q  <= err_drop_d;
        end
    end

    assign core_in_data  = in_fifo_data;
    assign out_fifo_data = core_out_data;
    assign core_start    = start_q;
    assign core_abort    = abort_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_count   = frame_cnt_q;
    assign err_timeout   = err_tmo_q;
    assign err_dropped   = err_drop_q;

endmodule
